// File: rtl/bsg_pkg.sv
// Shared constants, state type and Gray helper for the bsg_stream block.
package bsg_pkg;

    // Register map
    localparam logic [7:0] ADDR_CONTROL = 8'h00;
    localparam logic [7:0] ADDR_DATA    = 8'h01;
    localparam logic [7:0] ADDR_DIV     = 8'h02;
    localparam logic [7:0] ADDR_LEVEL   = 8'h03;
    localparam logic [7:0] ADDR_THRESH  = 8'h04;

    // CONTROL bit positions
    localparam int unsigned BIT_TXEN    = 0;
    localparam int unsigned BIT_INTMSK  = 1;
    localparam int unsigned BIT_INTFLAG = 2;
    localparam int unsigned BIT_STATUS  = 3;
    localparam int unsigned BIT_MODE    = 4;
    localparam int unsigned BIT_OVF     = 5;

    // Widest word the Gray helper accepts; callers zero-extend and truncate.
    localparam int unsigned GRAY_MAX_W  = 256;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Zero-extension is harmless: the Gray code of a zero-extended word,
    // truncated back, equals the Gray code at the original width.
    function automatic logic [GRAY_MAX_W-1:0] gray_encode(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/bsg_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit.
module bsg_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         head_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr[AW-1:0]];

    // Pointer update; a push while full is dropped even if a pop happens too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + LW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + LW'(1);
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/bsg_stream.sv
// FIFO-buffered symbol stream generator with register port and interrupt.
module bsg_stream
    import bsg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             SYS_CLK,
    input  logic             SYS_RST_N,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [7:0]       addr,
    input  logic [WIDTH-1:0] Data_in,
    output logic [WIDTH-1:0] Data_out,
    output logic             ready,
    output logic [WIDTH-1:0] OUT,
    output logic             BSG_INT
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       cnt;
    logic [7:0]       div;
    logic [LW-1:0]    thresh;
    logic [LW-1:0]    level;
    logic [LW-1:0]    level_after;
    logic             txen, intmsk, intflag, mode, ovf;
    logic             txen_nxt, intmsk_nxt, intflag_nxt, mode_nxt, ovf_nxt;
    logic             push, pop, full, empty;
    logic             sym_end, underrun, low_water;
    logic             ctrl_wr, reg_rd;
    logic [WIDTH-1:0] head, encoded, rd_data;

    assign ctrl_wr     = wr_en && (addr == ADDR_CONTROL);
    assign push        = wr_en && (addr == ADDR_DATA);
    assign reg_rd      = rd_en && !wr_en;
    assign sym_end     = (cnt >= div);
    assign encoded     = mode ? head : WIDTH'(gray_encode(GRAY_MAX_W'(head)));
    assign level_after = level - LW'(pop) + LW'(push && !full);
    assign low_water   = pop && (level_after <= thresh);

    bsg_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (SYS_CLK),
        .rst_n   (SYS_RST_N),
        .push    (push),
        .pop     (pop),
        .data_in (Data_in),
        .head_c  (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // FSM state register
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next state, pop decision and underrun detection
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        underrun  = 1'b0;
        case (state)
            IDLE: begin
                if (txen && !empty) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (sym_end) begin
                    if (txen && !empty) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        underrun  = txen;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Symbol period counter and symbol output
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            cnt <= '0;
            OUT <= '0;
        end else begin
            if (pop)                 cnt <= '0;
            else if (state == SEND)  cnt <= cnt + 8'd1;
            if (pop)                     OUT <= encoded;
            else if (state_nxt == IDLE)  OUT <= '0;
        end
    end

    // CONTROL next values; event sets win over write-1-to-clear
    always_comb begin
        txen_nxt    = txen;
        intmsk_nxt  = intmsk;
        mode_nxt    = mode;
        intflag_nxt = intflag;
        ovf_nxt     = ovf;
        if (ctrl_wr) begin
            txen_nxt   = Data_in[BIT_TXEN];
            intmsk_nxt = Data_in[BIT_INTMSK];
            mode_nxt   = Data_in[BIT_MODE];
            if (Data_in[BIT_INTFLAG]) intflag_nxt = 1'b0;
            if (Data_in[BIT_OVF])     ovf_nxt     = 1'b0;
        end
        if (low_water || underrun) intflag_nxt = 1'b1;
        if (push && full)          ovf_nxt     = 1'b1;
    end

    // Read data mux; unused bits read 0
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_CONTROL: begin
                rd_data[BIT_TXEN]    = txen;
                rd_data[BIT_INTMSK]  = intmsk;
                rd_data[BIT_INTFLAG] = intflag;
                rd_data[BIT_STATUS]  = (state == SEND);
                rd_data[BIT_MODE]    = mode;
                rd_data[BIT_OVF]     = ovf;
            end
            ADDR_DIV:    rd_data[7:0]    = div;
            ADDR_LEVEL:  rd_data[LW-1:0] = level;
            ADDR_THRESH: rd_data[LW-1:0] = thresh;
            default:     rd_data         = '0;
        endcase
    end

    // Register file, access handshake and interrupt output
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            txen     <= 1'b0;
            intmsk   <= 1'b0;
            intflag  <= 1'b0;
            mode     <= 1'b0;
            ovf      <= 1'b0;
            div      <= '0;
            thresh   <= '0;
            ready    <= 1'b0;
            Data_out <= '0;
            BSG_INT  <= 1'b0;
        end else begin
            txen     <= txen_nxt;
            intmsk   <= intmsk_nxt;
            intflag  <= intflag_nxt;
            mode     <= mode_nxt;
            ovf      <= ovf_nxt;
            if (wr_en && (addr == ADDR_DIV))    div    <= Data_in[7:0];
            if (wr_en && (addr == ADDR_THRESH)) thresh <= Data_in[LW-1:0];
            ready    <= wr_en || rd_en;
            Data_out <= reg_rd ? rd_data : '0;
            BSG_INT  <= intflag_nxt && intmsk_nxt;
        end
    end

endmodule

// File: tb/tb_bsg_stream.sv
// Scoreboard bench for bsg_stream: a queue-based reference model predicts
// every cycle's outputs, a monitor on the falling edge compares them.
module tb_bsg_stream;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 8;
    localparam int unsigned LW = $clog2(D) + 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [7:0]   addr  = 8'h00;
    logic [W-1:0] din   = '0;
    logic [W-1:0] dout;
    logic [W-1:0] out;
    logic         ready;
    logic         irq;

    int checks   = 0;
    int failures = 0;

    bsg_stream #(.WIDTH(W), .DEPTH(D)) dut (
        .SYS_CLK   (clk),
        .SYS_RST_N (rst_n),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .Data_in   (din),
        .Data_out  (dout),
        .ready     (ready),
        .OUT       (out),
        .BSG_INT   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] out;
        logic         irq;
        logic         rdy;
        logic         is_rd;
        logic [W-1:0] dout;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] mq[$];
    bit           m_txen, m_msk, m_flag, m_mode, m_ovf, m_send;
    int unsigned  m_div, m_thr, m_shown;
    logic [W-1:0] m_out;

    function automatic logic [W-1:0] model_read(input logic [7:0] a);
        case (a)
            8'h00:   return W'({m_ovf, m_mode, m_send, m_flag, m_msk, m_txen});
            8'h02:   return W'(m_div);
            8'h03:   return W'(mq.size());
            8'h04:   return W'(m_thr);
            default: return '0;
        endcase
    endfunction

    // A symbol is shown for div+1 cycles; at its end the next queued word
    // follows immediately, otherwise the stream stops (underrun if enabled).
    always @(posedge clk or negedge rst_n) begin : model
        bit           is_wr, is_rd, pop, und, ended, full_pre, lw;
        int unsigned  thr_pre;
        logic [W-1:0] w, rdv;
        exp_t         e;
        if (!rst_n) begin
            m_txen = 0; m_msk = 0; m_flag = 0; m_mode = 0; m_ovf = 0; m_send = 0;
            m_div = 0; m_thr = 0; m_shown = 0; m_out = '0;
            mq.delete();
            exp_q.delete();
        end else begin
            is_wr    = wr_en;
            is_rd    = rd_en && !wr_en;
            rdv      = model_read(addr);
            full_pre = (mq.size() == D);
            thr_pre  = m_thr;
            pop = 0; und = 0; ended = 0;
            if (!m_send) begin
                if (m_txen && mq.size() > 0) pop = 1;
            end else begin
                m_shown++;
                if (m_shown >= m_div + 1) begin
                    if (m_txen && mq.size() > 0) pop = 1;
                    else begin ended = 1; und = m_txen; end
                end
            end
            if (pop) begin
                w       = mq.pop_front();
                m_out   = m_mode ? w : (w ^ (w >> 1));
                m_send  = 1;
                m_shown = 0;
            end else if (ended) begin
                m_send = 0;
                m_out  = '0;
            end
            if (is_wr && addr == 8'h01) begin
                if (full_pre) m_ovf = 1;
                else          mq.push_back(din);
            end
            lw = pop && (mq.size() <= thr_pre);
            if (is_wr && addr == 8'h00) begin
                m_txen = din[0];
                m_msk  = din[1];
                m_mode = din[4];
                if (din[2]) m_flag = 0;
                if (din[5]) m_ovf  = 0;
            end
            if (is_wr && addr == 8'h02) m_div = din[7:0];
            if (is_wr && addr == 8'h04) m_thr = din[LW-1:0];
            if (lw || und) m_flag = 1;
            e.out   = m_out;
            e.irq   = m_flag && m_msk;
            e.rdy   = wr_en || rd_en;
            e.is_rd = is_rd;
            e.dout  = rdv;
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            chk("reset_out", out, '0);
            chk("reset_irq", W'(irq), '0);
            chk("reset_ready", W'(ready), '0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out", out, e.out);
            chk("irq", W'(irq), W'(e.irq));
            chk("ready", W'(ready), W'(e.rdy));
            if (e.is_rd) chk("read_data", dout, e.dout);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [7:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; addr = a; din = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [W-1:0] v);
        rd_en = 1'b1; addr = a;
        @(posedge clk); #1;
        rd_en = 1'b0;
        v = dout;
    endtask

    task automatic both(input logic [7:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; rd_en = 1'b1; addr = a; din = d;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin : stim
        logic [W-1:0] v;
        logic [W-1:0] gray_exp [9];
        int           r;
        logic [W-1:0] d;
        gray_exp = '{8'h07, 8'h07, 8'h05, 8'h05, 8'h05, 8'h04, 8'h04, 8'h04, 8'h00};

        // Reset values
        #1;
        chk("por_out", out, '0);
        chk("por_data_out", dout, '0);
        chk("por_irq", W'(irq), '0);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;
        rd(8'h00, v); chk("por_control", v, 8'h00);
        rd(8'h03, v); chk("por_level", v, 8'h00);

        // Gray stream, DIV=2
        wr(8'h02, 8'd2);
        wr(8'h00, 8'h01);
        wr(8'h01, 8'h05);
        wr(8'h01, 8'h06);
        wr(8'h01, 8'h07);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("gray_seq", out, gray_exp[i]);
        end
        idle(1);
        rd(8'h00, v); chk("gray_underrun_ctrl", v, 8'h05);
        wr(8'h00, 8'h04);

        // Binary, DIV=0: two edges from strobe, one cycle long
        wr(8'h02, 8'd0);
        wr(8'h00, 8'h11);
        wr(8'h01, 8'hA5);
        @(negedge clk); chk("bin_before", out, 8'h00);
        @(negedge clk); chk("bin_symbol", out, 8'hA5);
        @(negedge clk); chk("bin_after", out, 8'h00);
        wr(8'h00, 8'h04);

        // Overflow with TXEN=0
        for (int i = 0; i < 9; i++) wr(8'h01, W'(8'h10 + i));
        rd(8'h03, v); chk("ovf_level", v, 8'd8);
        rd(8'h00, v); chk("ovf_ctrl", v, 8'h20);
        wr(8'h00, 8'h20);
        rd(8'h00, v); chk("ovf_cleared", v, 8'h00);
        wr(8'h00, 8'h11);
        idle(15);
        rd(8'h03, v); chk("ovf_drained", v, 8'h00);
        wr(8'h00, 8'h04);

        // Low-water interrupt on the second pop
        wr(8'h04, 8'd1);
        wr(8'h02, 8'd3);
        wr(8'h00, 8'h02);
        wr(8'h01, 8'h31);
        wr(8'h01, 8'h32);
        wr(8'h01, 8'h33);
        wr(8'h00, 8'h03);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("lw_irq_low", W'(irq), 8'h00);
        end
        @(negedge clk); chk("lw_irq_rise", W'(irq), 8'h01);
        idle(12);
        wr(8'h00, 8'h06);
        @(negedge clk); chk("lw_irq_cleared", W'(irq), 8'h00);
        wr(8'h00, 8'h00);
        wr(8'h04, 8'd0);

        // Disable mid-symbol, DIV=4
        wr(8'h02, 8'd4);
        wr(8'h00, 8'h01);
        wr(8'h01, 8'h41);
        wr(8'h01, 8'h42);
        idle(1);
        wr(8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("dis_hold", out, 8'h61);
        end
        @(negedge clk); chk("dis_idle", out, 8'h00);
        idle(4);
        rd(8'h03, v); chk("dis_level", v, 8'd1);
        rd(8'h00, v); chk("dis_ctrl", v, 8'h00);

        // Asynchronous reset in the middle of a symbol
        wr(8'h02, 8'd5);
        wr(8'h00, 8'h13);
        wr(8'h01, 8'h55);
        wr(8'h01, 8'h66);
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", out, 8'h00);
        chk("arst_irq", W'(irq), 8'h00);
        chk("arst_ready", W'(ready), 8'h00);
        chk("arst_data_out", dout, 8'h00);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        idle(20);
        rd(8'h00, v); chk("arst_ctrl", v, 8'h00);
        rd(8'h03, v); chk("arst_level", v, 8'h00);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 35) begin
                wr(8'h01, W'($urandom));
            end else if (r < 45) begin
                d = W'($urandom) & 8'h3F;
                if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                wr(8'h00, d);
            end else if (r < 52) begin
                wr(8'h02, W'($urandom_range(0, 3)));
            end else if (r < 57) begin
                wr(8'h04, W'($urandom_range(0, D)));
            end else if (r < 80) begin
                rd(8'($urandom_range(0, 7)), v);
            end else if (r < 83) begin
                both(8'($urandom_range(0, 4)), W'($urandom_range(0, 3)));
            end else begin
                idle($urandom_range(1, 4));
            end
        end

        // Drain
        wr(8'h00, 8'h01);
        wr(8'h02, 8'd0);
        idle(40);
        rd(8'h03, v); chk("final_level", v, 8'h00);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
